// File: rtl/ladybird_aclint.sv
// Machine-level CLINT slice: MSIP, MTIMECMP and a free-running MTIME behind an AXI-Lite slave.
// One outstanding read and one outstanding write; mtip is a registered compare of mtime against mtimecmp.
module ladybird_aclint #(
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rtc_tick,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [AXI_ADDR_W-1:0] awaddr,
    input  logic                  wvalid,
    output logic                  wready,
    input  logic [AXI_DATA_W-1:0] wdata,
    input  logic [3:0]            wstrb,
    output logic                  bvalid,
    input  logic                  bready,
    output logic [1:0]            bresp,
    input  logic                  arvalid,
    output logic                  arready,
    input  logic [AXI_ADDR_W-1:0] araddr,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [AXI_DATA_W-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  msip,
    output logic                  mtip
);
    typedef enum logic [2:0] {
        SEL_NONE, SEL_MSIP, SEL_CMP_LO, SEL_CMP_HI, SEL_TIME_LO, SEL_TIME_HI
    } sel_t;

    typedef enum logic { W_IDLE, W_RESP } w_state_t;
    typedef enum logic { R_IDLE, R_DATA } r_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    w_state_t    w_state;
    r_state_t    r_state;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic        msip_q;
    logic        tick_q;
    sel_t        wsel;
    sel_t        rsel;
    logic        wr_fire;
    logic        rd_fire;
    logic        tick_rise;
    logic [31:0] rd_value;
    logic        unused_addr_bits;

    function automatic sel_t decode(input logic [15:0] off);
        case (off)
            16'h0000: decode = SEL_MSIP;
            16'h4000: decode = SEL_CMP_LO;
            16'h4004: decode = SEL_CMP_HI;
            16'hBFF8: decode = SEL_TIME_LO;
            16'hBFFC: decode = SEL_TIME_HI;
            default:  decode = SEL_NONE;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] strb);
        for (int i = 0; i < 4; i++) begin
            merge[8*i +: 8] = strb[i] ? nw[8*i +: 8] : old[8*i +: 8];
        end
    endfunction

    assign unused_addr_bits = ^{awaddr[AXI_ADDR_W-1:16], araddr[AXI_ADDR_W-1:16]};

    assign wsel      = decode(awaddr[15:0]);
    assign rsel      = decode(araddr[15:0]);
    assign awready   = (w_state == W_IDLE) && awvalid && wvalid;
    assign wready    = awready;
    assign arready   = (r_state == R_IDLE);
    assign wr_fire   = awready;
    assign rd_fire   = arready && arvalid;
    assign tick_rise = rtc_tick && !tick_q;
    assign msip      = msip_q;

    always_comb begin
        rd_value = '0;
        case (rsel)
            SEL_MSIP:    rd_value = {31'd0, msip_q};
            SEL_CMP_LO:  rd_value = mtimecmp[31:0];
            SEL_CMP_HI:  rd_value = mtimecmp[63:32];
            SEL_TIME_LO: rd_value = mtime[31:0];
            SEL_TIME_HI: rd_value = mtime[63:32];
            default:     rd_value = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mtime    <= '0;
            mtimecmp <= '1;
            msip_q   <= 1'b0;
            mtip     <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            tick_q <= rtc_tick;
            mtip   <= (mtime >= mtimecmp);
            // A bus write to either MTIME half swallows a coincident tick.
            if (wr_fire && wsel == SEL_TIME_LO) begin
                mtime[31:0] <= merge(mtime[31:0], wdata[31:0], wstrb);
            end else if (wr_fire && wsel == SEL_TIME_HI) begin
                mtime[63:32] <= merge(mtime[63:32], wdata[31:0], wstrb);
            end else if (tick_rise) begin
                mtime <= mtime + 64'd1;
            end
            if (wr_fire && wsel == SEL_MSIP && wstrb[0]) msip_q <= wdata[0];
            if (wr_fire && wsel == SEL_CMP_LO)
                mtimecmp[31:0] <= merge(mtimecmp[31:0], wdata[31:0], wstrb);
            if (wr_fire && wsel == SEL_CMP_HI)
                mtimecmp[63:32] <= merge(mtimecmp[63:32], wdata[31:0], wstrb);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state <= W_IDLE;
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: if (wr_fire) begin
                    w_state <= W_RESP;
                    bvalid  <= 1'b1;
                    bresp   <= (wsel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
                end
                W_RESP: if (bready) begin
                    w_state <= W_IDLE;
                    bvalid  <= 1'b0;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= R_IDLE;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: if (rd_fire) begin
                    r_state <= R_DATA;
                    rvalid  <= 1'b1;
                    rdata   <= AXI_DATA_W'(rd_value);
                    rresp   <= (rsel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
                end
                R_DATA: if (rready) begin
                    r_state <= R_IDLE;
                    rvalid  <= 1'b0;
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ladybird_aclint.sv
// Scoreboarded bench for ladybird_aclint: a register-level model predicts every response,
// a negedge monitor pops and compares whenever a response handshake is about to complete.
module tb_ladybird_aclint;
    logic        clk = 1'b0;
    logic        rst, rtc_tick;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready, msip, mtip;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    int checks = 0;
    int errors = 0;

    logic [1:0]  bq[$];
    logic [33:0] rq[$];

    logic [63:0] m_mtime, m_cmp;
    logic        m_msip;

    always #5 clk = ~clk;

    ladybird_aclint #(.AXI_ADDR_W(32), .AXI_DATA_W(32)) dut (
        .clk(clk), .rst(rst), .rtc_tick(rtc_tick),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .msip(msip), .mtip(mtip)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bvalid && bready) begin
            if (bq.size() == 0) chk("unexpected_bvalid", 1, 0);
            else chk("bresp", bresp, bq.pop_front());
        end
        if (!rst && rvalid && rready) begin
            if (rq.size() == 0) chk("unexpected_rvalid", 1, 0);
            else begin
                logic [33:0] e;
                e = rq.pop_front();
                chk("rdata", rdata, e[31:0]);
                chk("rresp", rresp, e[33:32]);
            end
        end
    end

    // Reference register map, addressed by the low 16 bits only.
    function automatic int reg_of(input logic [31:0] a);
        case (a[15:0])
            16'h0000: return 1;
            16'h4000: return 2;
            16'h4004: return 3;
            16'hBFF8: return 4;
            16'hBFFC: return 5;
            default:  return 0;
        endcase
    endfunction

    function automatic logic [31:0] bytes_merge(input logic [31:0] o, input logic [31:0] n,
                                                input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        case (reg_of(a))
            1: if (s[0]) m_msip = d[0];
            2: m_cmp[31:0]    = bytes_merge(m_cmp[31:0], d, s);
            3: m_cmp[63:32]   = bytes_merge(m_cmp[63:32], d, s);
            4: m_mtime[31:0]  = bytes_merge(m_mtime[31:0], d, s);
            5: m_mtime[63:32] = bytes_merge(m_mtime[63:32], d, s);
            default: ;
        endcase
    endtask

    function automatic logic [33:0] model_read(input logic [31:0] a);
        case (reg_of(a))
            1: return {2'b00, 31'd0, m_msip};
            2: return {2'b00, m_cmp[31:0]};
            3: return {2'b00, m_cmp[63:32]};
            4: return {2'b00, m_mtime[31:0]};
            5: return {2'b00, m_mtime[63:32]};
            default: return {2'b10, 32'd0};
        endcase
    endfunction

    task automatic model_reset();
        m_mtime = 64'd0;
        m_cmp   = '1;
        m_msip  = 1'b0;
    endtask

    task automatic wait_b();
        for (int i = 0; i < 50 && bq.size() != 0; i++) @(posedge clk);
        #1;
        if (bq.size() != 0) begin chk("b_timeout", bq.size(), 0); bq.delete(); end
    endtask

    task automatic wait_r();
        for (int i = 0; i < 50 && rq.size() != 0; i++) @(posedge clk);
        #1;
        if (rq.size() != 0) begin chk("r_timeout", rq.size(), 0); rq.delete(); end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic with_tick, input logic wait_done);
        logic hs;
        hs = 1'b0;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        if (with_tick) rtc_tick = 1'b1;
        bq.push_back(reg_of(a) != 0 ? 2'b00 : 2'b10);
        model_write(a, d, s);
        for (int i = 0; i < 20 && !hs; i++) begin
            @(negedge clk);
            hs = awready && wready;
            @(posedge clk);
        end
        #1;
        awvalid = 1'b0; wvalid = 1'b0;
        if (with_tick) rtc_tick = 1'b0;
        if (!hs) chk("aw_handshake_timeout", 0, 1);
        if (wait_done) wait_b();
    endtask

    task automatic do_read(input logic [31:0] a, input logic wait_done);
        logic hs;
        hs = 1'b0;
        araddr = a; arvalid = 1'b1;
        rq.push_back(model_read(a));
        for (int i = 0; i < 20 && !hs; i++) begin
            @(negedge clk);
            hs = arready;
            @(posedge clk);
        end
        #1;
        arvalid = 1'b0;
        if (!hs) chk("ar_handshake_timeout", 0, 1);
        if (wait_done) wait_r();
    endtask

    task automatic tick();
        rtc_tick = 1'b1;
        m_mtime = m_mtime + 64'd1;
        repeat (2) @(posedge clk);
        #1 rtc_tick = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_irq();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("msip", msip, m_msip);
        chk("mtip", mtip, (m_mtime >= m_cmp) ? 1 : 0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [15:0] offs [8];
        offs = '{16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC, 16'h0008, 16'h4002, 16'h0004};
        return {16'($urandom), offs[$urandom_range(0, 7)]};
    endfunction

    initial begin
        rst = 1'b1; rtc_tick = 1'b0;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_msip", msip, 0);
        chk("rst_mtip", mtip, 0);
        @(posedge clk); #1;

        do_read(32'h0000_BFF8, 1);
        do_read(32'h0000_4004, 1);
        check_irq();

        do_write(32'h0000_4000, 32'hAABB_CCDD, 4'b0101, 0, 1);
        chk("strobe_model", m_cmp[31:0], 32'hFFBB_FFDD);
        do_read(32'h0000_4000, 1);

        do_write(32'h0000_0000, 32'h1, 4'hF, 0, 1);
        check_irq();
        do_write(32'h0000_0000, 32'h0, 4'hF, 0, 1);
        check_irq();

        do_write(32'h0000_4000, 32'd5, 4'hF, 0, 1);
        do_write(32'h0000_4004, 32'd0, 4'hF, 0, 1);
        repeat (4) tick();
        check_irq();
        rtc_tick = 1'b1;
        m_mtime = m_mtime + 64'd1;
        @(negedge clk); chk("mtip_before_edge", mtip, 0);
        @(negedge clk); chk("mtip_one_cycle", mtip, 0);
        @(negedge clk); chk("mtip_two_cycles", mtip, 1);
        @(posedge clk); #1 rtc_tick = 1'b0;
        repeat (2) @(posedge clk); #1;

        do_write(32'h0000_BFF8, 32'hFFFF_FFFF, 4'hF, 0, 1);
        do_write(32'h0000_BFFC, 32'hFFFF_FFFF, 4'hF, 0, 1);
        tick();
        do_read(32'h0000_BFF8, 1);
        do_read(32'h0000_BFFC, 1);
        check_irq();

        // Write and tick land on the same edge: the write value sticks, the tick is dropped.
        do_write(32'h0000_BFF8, 32'h0000_1234, 4'hF, 1, 1);
        repeat (2) @(posedge clk); #1;
        do_read(32'h0000_BFF8, 1);
        do_read(32'h0000_BFFC, 1);

        // Read and write to the same register accepted together: read sees the old value.
        rq.push_back(model_read(32'h0000_4000));
        bq.push_back(2'b00);
        model_write(32'h0000_4000, 32'h0BAD_F00D, 4'hF);
        awaddr = 32'h0000_4000; wdata = 32'h0BAD_F00D; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; araddr = 32'h0000_4000; arvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        wait_b(); wait_r();
        do_read(32'h0000_4000, 1);

        do_read(32'h0000_0008, 1);
        do_read(32'h0000_4002, 1);
        bready = 1'b0;
        do_write(32'h0000_0008, 32'h1234_5678, 4'hF, 0, 0);
        awaddr = 32'h0000_0010; wdata = 32'h0; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bvalid_hold", bvalid, 1);
            chk("bresp_hold", bresp, 2'b10);
            chk("awready_low", awready, 0);
        end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        wait_b();

        for (int n = 0; n < 150; n++) begin
            int op;
            op = int'($urandom_range(0, 9));
            if (op < 4) do_write(rand_addr(), $urandom, 4'($urandom), 0, 1);
            else if (op < 8) do_read(rand_addr(), 1);
            else if (op == 8) tick();
            else check_irq();
        end
        check_irq();

        rready = 1'b0;
        do_read(32'h0000_4004, 0);
        @(negedge clk); chk("rvalid_pending", rvalid, 1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_rvalid", rvalid, 0);
        chk("abort_mtip", mtip, 0);
        rq.delete();
        model_reset();
        rready = 1'b1;
        @(posedge clk); #1;
        do_read(32'h0000_BFF8, 1);
        do_read(32'h0000_0000, 1);

        if (bq.size() != 0 || rq.size() != 0) chk("queues_drained", bq.size() + rq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ladybird_aclint.md
LADYBIRD_ACLINT -- requirements
Module: ladybird_aclint

Interface
REQ-001 SHALL have parameter AXI_ADDR_W, default 32, meaning AXI-Lite address width.
REQ-002 SHALL have parameter AXI_DATA_W, default 32, meaning AXI-Lite data width (only 32 supported).
REQ-003 SHALL have port clk, input, 1, single clock for all state.
REQ-004 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port rtc_tick, input, 1, timebase level signal; each rising edge advances mtime.
REQ-006 SHALL have ports awvalid/awready (in/out, 1) and awaddr (in, AXI_ADDR_W), the write-address channel.
REQ-007 SHALL have ports wvalid/wready (in/out, 1), wdata (in, 32) and wstrb (in, 4), the write-data channel.
REQ-008 SHALL have ports bvalid/bready (out/in, 1) and bresp (out, 2), the write-response channel.
REQ-009 SHALL have ports arvalid/arready (in/out, 1) and araddr (in, AXI_ADDR_W), the read-address channel.
REQ-010 SHALL have ports rvalid/rready (out/in, 1), rdata (out, 32) and rresp (out, 2), the read-data channel.
REQ-011 SHALL have port msip, output, 1, machine software interrupt pending.
REQ-012 SHALL have port mtip, output, 1, machine timer interrupt pending.

Function
REQ-013 SHALL decode only addr[15:0]: 0x0000 MSIP (bit0 only, other bits read 0), 0x4000/0x4004 MTIMECMP lo/hi, 0xBFF8/0xBFFC MTIME lo/hi.
REQ-014 SHALL reject unaligned or unmapped offsets with resp 2'b10 (SLVERR), no state change, rdata 0; mapped accesses SHALL return 2'b00.
REQ-015 SHALL run the write FSM W_IDLE -> W_RESP: in W_IDLE, awready = wready = (awvalid & wvalid); on that handshake apply the write and go to W_RESP.
REQ-016 SHALL, in W_RESP, assert bvalid with bresp held stable until bready, then return to W_IDLE; awready and wready SHALL be low in W_RESP.
REQ-017 SHALL run the read FSM R_IDLE -> R_DATA: arready = 1 in R_IDLE; on the handshake, capture rdata/rresp from current register values and assert rvalid on the next cycle.
REQ-018 SHALL, in R_DATA, hold rvalid, rdata and rresp stable until rready, then return to R_IDLE; arready SHALL be low in R_DATA.
REQ-019 SHALL run the read and write FSMs independently, allowing one outstanding transaction each.
REQ-020 SHALL apply wstrb per byte on all registers; bytes with a 0 strobe are unchanged.
REQ-021 SHALL register rtc_tick once and increment 64-bit mtime by 1 (wrapping at 2^64-1 to 0) on the cycle the registered value goes 0->1.
REQ-022 SHALL give a bus write to MTIME lo or hi priority over a simultaneous increment: only the written value is stored, and that increment is lost.
REQ-023 SHALL register mtip as (mtime >= mtimecmp), an unsigned 64-bit compare, so mtip reflects register values one cycle later.
REQ-024 SHALL drive msip directly from the MSIP register bit0.
REQ-025 SHALL return the pre-write value when a read and a write to the same register are accepted in the same cycle.

Reset
REQ-026 SHALL, on rst high at a clk edge, set mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, MSIP=0, mtip=0, tick register=0, both FSMs idle, bvalid=rvalid=0, bresp=rresp=0, rdata=0.
REQ-027 SHALL let rst abort an in-flight response: bvalid/rvalid drop the cycle after reset with no handshake required.

Verification
REQ-028 SHALL pass: after reset, read 0xBFF8 -> rdata 0x0, rresp 0; read 0x4004 -> 0xFFFFFFFF; mtip=0, msip=0.
REQ-029 SHALL pass: write 0x1 (wstrb 4'hF) to 0x0000 -> bresp 0, msip=1; write 0x0 -> msip=0.
REQ-030 SHALL pass: write mtimecmp lo=5, hi=0, then pulse rtc_tick 5 times -> mtip=1 two cycles after the 5th rising edge, not before.
REQ-031 SHALL pass: write 0xFFFFFFFF to 0xBFF8 and 0xBFFC, one tick -> mtime reads 0 in both halves.
REQ-032 SHALL pass: write 0xAABBCCDD to 0x4000 with wstrb 4'b0101 -> reads 0xFFBBFFDD.
REQ-033 SHALL pass: read 0x0008, and hold bready low 3 cycles on a write -> SLVERR with rdata 0; bvalid held 3 cycles, awready low throughout.
